avr_fetch_queue: RTL and testbench
==================================

AVR_FETCH_QUEUE -- requirements
Module: avr_fetch_queue

Interface
REQ-001 Parameter PC_W, default 16, program-counter and p_addr width in words.
REQ-002 Parameter DEPTH, default 4, queue entries of 16 bits; SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 RST  in  1  reset, asynchronous and active-low.
REQ-006 p_addr  out  PC_W  program-memory word address.
REQ-007 p_rd  out  1  read request; p_addr is valid while p_rd is high.
REQ-008 p_data  in  16  program word, returned exactly 1 cycle after p_rd.
REQ-009 p_valid  in  1  qualifies p_data; high exactly 1 cycle after each p_rd.
REQ-010 jump_en  in  1  redirect and flush request.
REQ-011 jump_addr  in  PC_W  redirect target.
REQ-012 instr  out  16  head instruction word for the decoder.
REQ-013 instr2  out  16  second word of a 32-bit instruction; 0 otherwise.
REQ-014 instr_is32  out  1  head is a two-word instruction.
REQ-015 instr_pc  out  PC_W  word address of the head instruction.
REQ-016 instr_valid  out  1  head instruction is complete and presentable.
REQ-017 instr_ready  in  1  consumer accepts the head when instr_valid is high.

Function
REQ-018 p_rd SHALL be high when RST is high, jump_en is low, and (count + inflight) < DEPTH; a pop in the same cycle SHALL NOT be credited.
REQ-019 Each issued read SHALL increment the fetch PC by 1, modulo 2^PC_W (wrap from all-ones to 0).
REQ-020 A word arriving with p_valid SHALL be written at the tail with its PC; a word written in cycle N SHALL be visible at the head in cycle N+1.
REQ-021 First-fetch latency after reset release SHALL be 2 cycles: p_rd in cycle 0, instr_valid in cycle 2.
REQ-022 The outputs instr, instr_pc, and instr_is32 SHALL be driven from the head storage registers; instr_valid SHALL be derived from count and the head opcode.
REQ-023 Two-word opcodes are LDS (1001000xxxxx0000), STS (1001001xxxxx0000), JMP (1001010xxxxx110x), and CALL (1001010xxxxx111x).
REQ-024 For a two-word head, instr_valid SHALL be high only when count >= 2; the handshake SHALL then pop 2 entries.
REQ-025 For a one-word head, the handshake SHALL pop 1 entry.
REQ-026 A push and a pop in the same cycle SHALL both take effect; count SHALL never exceed DEPTH or go below 0.
REQ-027 jump_en SHALL cause the following:
  - count is cleared;
  - the head and tail pointers are reset;
  - inflight is cleared;
  - the fetch PC is set to jump_addr;
  - p_rd is held low for that cycle.
REQ-028 On a jump_en cycle, any concurrent p_valid word SHALL be discarded and any concurrent pop SHALL be ignored; jump_en takes priority.
REQ-029 The first fetch from jump_addr SHALL issue in the cycle after jump_en; no pre-jump word SHALL ever reach instr.
REQ-030 instr_valid SHALL be low while the queue is empty or holds only the first word of a two-word instruction.

Reset
REQ-031 On RST low, immediately and regardless of the clock:
  - fetch PC is set to RESET_VEC;
  - count, pointers, and inflight are set to 0;
  - p_rd, instr_valid, and instr_is32 are set to 0;
  - instr and instr2 are set to 0;
  - instr_pc is set to RESET_VEC.
REQ-032 RST asserted in the middle of an operation SHALL abandon any in-flight read; a p_valid arriving in the first cycle after release SHALL be ignored.

Configuration
REQ-033 Macro AVR_FETCH_2W_EN defined: two-word assembly per REQ-023, REQ-024, and REQ-030 is enabled.
REQ-034 Macro AVR_FETCH_2W_EN undefined: every entry is presented as a one-word instruction; instr2 and instr_is32 are tied to 0; every pop removes 1 entry.

Structure
REQ-035 Shared package avr_pkg SHALL hold the following:
  - the two-word opcode mask and match constants;
  - an is_two_word function;
  - the NOP constant 16'h0000.
REQ-036 Storage SHALL be one sub-module, avr_ifq_mem:
  - a DEPTH x (16 + PC_W) register array;
  - one write port;
  - two combinational read ports (head and head+1).

Verification
REQ-037 Hold RST low, then release it with instr_ready=0 and DEPTH=4 -> p_addr steps 0,1,2,3; p_rd then drops low; count=4 and instr_valid=1.
REQ-038 Program memory holds 0x50A1, 0x0000, 0xE800, 0xE011, 0x0F01; instr_ready=1 -> instr sequence is 0x50A1, 0x0000, 0xE800, 0xE011, 0x0F01 on consecutive cycles starting at cycle 2.
REQ-039 Memory holds 0x9100, 0x0100 (LDS) at address 0 -> one handshake with instr=0x9100, instr2=0x0100, instr_is32=1, instr_pc=0; the next instr_pc is 2.
REQ-040 Queue full, p_valid high, and jump_en=1 with jump_addr=0x0040 -> next cycle count=0, p_addr=0x0040, p_rd=1; the first instr_pc presented is 0x0040.
REQ-041 PC_W=8 with a jump to 0xFF -> fetches issue at 0xFF, then 0x00; instr_pc follows 0xFF, 0x00.
REQ-042 RST dropped low in the middle of a cycle with the queue half full -> p_rd and instr_valid are 0 before the next edge; after release, fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared AVR definitions: the NOP word and two-word opcode decoding
// (LDS, STS, JMP, CALL) used by the instruction fetch queue.
package avr_pkg;

    localparam logic [15:0] NOP = 16'h0000;

    // Mask/match pairs; x bits of each opcode pattern are cleared in the mask.
    localparam logic [15:0] LDS_MASK   = 16'hFE0F;
    localparam logic [15:0] LDS_MATCH  = 16'h9000;
    localparam logic [15:0] STS_MASK   = 16'hFE0F;
    localparam logic [15:0] STS_MATCH  = 16'h9200;
    localparam logic [15:0] JMP_MASK   = 16'hFE0E;
    localparam logic [15:0] JMP_MATCH  = 16'h940C;
    localparam logic [15:0] CALL_MASK  = 16'hFE0E;
    localparam logic [15:0] CALL_MATCH = 16'h940E;

    function automatic logic is_two_word(input logic [15:0] word);
        return ((word & LDS_MASK)  == LDS_MATCH)  ||
               ((word & STS_MASK)  == STS_MATCH)  ||
               ((word & JMP_MASK)  == JMP_MATCH)  ||
               ((word & CALL_MASK) == CALL_MATCH);
    endfunction

endpackage

// File: rtl/avr_ifq_mem.sv
// Fetch-queue storage: DEPTH entries of {pc, word}, one write port and
// two combinational read ports (head and head+1).
module avr_ifq_mem
    import avr_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    localparam int             AW        = $clog2(DEPTH),
    localparam int             DW        = 16 + PC_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array is reset so the head fields read as NOP/RESET_VEC
    // straight out of reset instead of X; it is small enough to afford it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {RESET_VEC, NOP};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/avr_fetch_queue.sv
// AVR instruction fetch queue: prefetches program words into a small FIFO and
// presents whole instructions. Define AVR_FETCH_2W_EN for two-word assembly.
module avr_fetch_queue #(
    parameter int              PC_W      = 16,
    parameter int              DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    output logic [PC_W-1:0] p_addr,
    output logic            p_rd,
    input  logic [15:0]     p_data,
    input  logic            p_valid,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic [15:0]     instr,
    output logic [15:0]     instr2,
    output logic            instr_is32,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready
);
    import avr_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = 16 + PC_W;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [AW-1:0]   head_ptr;
    logic [AW-1:0]   tail_ptr;

    logic [DW-1:0]   head_ent;
    logic [DW-1:0]   next_ent;
    logic [15:0]     head_word;
    logic [15:0]     next_word;
    logic            head_is32;
    logic            has_one;
    logic            has_two;
    logic [CW:0]     occupancy;
    logic            push;
    logic            pop;
    logic [CW-1:0]   pop_cnt;

    assign head_word = head_ent[15:0];
    assign next_word = next_ent[15:0];

`ifdef AVR_FETCH_2W_EN
    assign head_is32 = is_two_word(head_word);
`else
    assign head_is32 = 1'b0;
`endif

    assign has_one   = (count != '0);
    assign has_two   = (count >= CW'(2));
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

    // NOTE: p_rd is gated by RST combinationally so it drops the instant reset
    // asserts; a registered gate would only fall at the next edge.
    assign p_rd   = RST && !jump_en && (occupancy < (CW + 1)'(DEPTH));
    assign p_addr = fetch_pc;

    // A word only counts if a read is outstanding, so a stray p_valid right
    // after reset or a flush can never enter the queue.
    assign push = p_valid && inflight && !jump_en;

    assign instr_valid = has_one && (!head_is32 || has_two);
    assign instr_is32  = has_one && head_is32;
    assign instr       = has_one ? head_word : NOP;
    assign instr2      = (instr_is32 && has_two) ? next_word : NOP;
    assign instr_pc    = head_ent[DW-1:16];

    assign pop = instr_valid && instr_ready && !jump_en;

    always_comb begin
        pop_cnt = '0;
        if (pop) begin
            pop_cnt = instr_is32 ? CW'(2) : CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_pc    <= RESET_VEC;
            inflight_pc <= RESET_VEC;
            inflight    <= 1'b0;
            count       <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
        end else if (jump_en) begin
            fetch_pc    <= jump_addr;
            inflight    <= 1'b0;
            count       <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
        end else begin
            // Memory answers exactly one cycle later, so at most one read is open.
            inflight <= p_rd;
            if (p_rd) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            head_ptr <= head_ptr + AW'(pop_cnt);
            count    <= count + CW'(push) - pop_cnt;
        end
    end

    avr_ifq_mem #(
        .DEPTH     (DEPTH),
        .PC_W      (PC_W),
        .RESET_VEC (RESET_VEC)
    ) u_mem (
        .CLK    (CLK),
        .RST    (RST),
        .we     (push),
        .waddr  (tail_ptr),
        .wdata  ({inflight_pc, p_data}),
        .raddr0 (head_ptr),
        .raddr1 (head_ptr + 1'b1),
        .rdata0 (head_ent),
        .rdata1 (next_ent)
    );

endmodule

// File: tb/tb_avr_fetch_queue.sv
// Self-checking bench for avr_fetch_queue: directed scenarios plus random
// traffic against a queue-level reference model; a PC_W=8 instance covers wrap.
module tb_avr_fetch_queue;

    localparam int DEPTH = 4;
`ifdef AVR_FETCH_2W_EN
    localparam bit TWO_W = 1'b1;
`else
    localparam bit TWO_W = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    always #5 CLK = ~CLK;

    // main instance, PC_W = 16
    logic [15:0] p_addr;
    logic        p_rd;
    logic [15:0] p_data;
    logic        p_valid;
    logic        jump_en = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [15:0] instr, instr2;
    logic        instr_is32;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    // wrap instance, PC_W = 8
    logic [7:0]  p_addr8;
    logic        p_rd8;
    logic [15:0] p_data8;
    logic        p_valid8;
    logic        jump_en8 = 1'b0;
    logic [7:0]  jump_addr8 = '0;
    logic [15:0] instr8, instr2_8;
    logic        instr_is32_8;
    logic [7:0]  instr_pc8;
    logic        instr_valid8;

    avr_fetch_queue #(.PC_W(16), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) u_dut (
        .CLK(CLK), .RST(RST), .p_addr(p_addr), .p_rd(p_rd), .p_data(p_data),
        .p_valid(p_valid), .jump_en(jump_en), .jump_addr(jump_addr),
        .instr(instr), .instr2(instr2), .instr_is32(instr_is32),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    avr_fetch_queue #(.PC_W(8), .DEPTH(DEPTH), .RESET_VEC(8'h00)) u_dut8 (
        .CLK(CLK), .RST(RST), .p_addr(p_addr8), .p_rd(p_rd8), .p_data(p_data8),
        .p_valid(p_valid8), .jump_en(jump_en8), .jump_addr(jump_addr8),
        .instr(instr8), .instr2(instr2_8), .instr_is32(instr_is32_8),
        .instr_pc(instr_pc8), .instr_valid(instr_valid8), .instr_ready(1'b1)
    );

    // program memories: one-cycle read latency
    logic [15:0] prog [256];
    logic        rsp_valid = 1'b0, rsp_valid8 = 1'b0, inj_valid = 1'b0;
    logic [15:0] rsp_data = '0, rsp_data8 = '0;

    always @(posedge CLK) begin
        rsp_valid  <= p_rd;
        rsp_data   <= prog[p_addr[7:0]];
        rsp_valid8 <= p_rd8;
        rsp_data8  <= {8'h5A, p_addr8};
    end

    assign p_valid  = rsp_valid | inj_valid;
    assign p_data   = inj_valid ? 16'hDEAD : rsp_data;
    assign p_valid8 = rsp_valid8;
    assign p_data8  = rsp_data8;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: queue of {word, pc}, fetch pc, one outstanding read
    typedef struct packed {
        logic [15:0] w;
        logic [15:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mpc;
    bit          pend;
    logic [15:0] pend_pc;

    function automatic bit is2w(input logic [15:0] w);
        if (!TWO_W) return 1'b0;
        return (w ==? 16'b1001000?????0000) || (w ==? 16'b1001001?????0000) ||
               (w ==? 16'b1001010?????110?) || (w ==? 16'b1001010?????111?);
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc     = 16'h0000;
        pend    = 1'b0;
        pend_pc = 16'h0000;
    endtask

    task automatic step(input bit rdy, input bit jmp, input logic [15:0] ja);
        bit          exp_rd, exp_valid, two, pv;
        logic [15:0] pd;
        int          n;
        ent_t        e;
        @(negedge CLK);
        instr_ready = rdy;
        jump_en     = jmp;
        jump_addr   = ja;
        #1;
        pv        = p_valid;
        pd        = p_data;
        n         = mq.size();
        exp_rd    = !jmp && ((n + int'(pend)) < DEPTH);
        two       = (n > 0) && is2w(mq[0].w);
        exp_valid = (n > 0) && (!two || n >= 2);
        check("p_rd", p_rd, exp_rd);
        if (exp_rd) check("p_addr", p_addr, mpc);
        check("instr_valid", instr_valid, exp_valid);
        if (exp_valid) begin
            check("instr", instr, mq[0].w);
            check("instr_pc", instr_pc, mq[0].pc);
            check("instr_is32", instr_is32, two);
            check("instr2", instr2, two ? mq[1].w : 16'h0000);
        end
        @(posedge CLK);
        if (jmp) begin
            mq.delete();
            pend = 1'b0;
            mpc  = ja;
        end else begin
            if (exp_valid && rdy) begin
                void'(mq.pop_front());
                if (two) void'(mq.pop_front());
            end
            if (pv && pend) begin
                e.w  = pd;
                e.pc = pend_pc;
                mq.push_back(e);
            end
            pend = exp_rd;
            if (exp_rd) begin
                pend_pc = mpc;
                mpc     = mpc + 16'h0001;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST         = 1'b0;
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = '0;
        jump_en8    = 1'b0;
        #1;
        model_reset();
        check("rst_p_rd", p_rd, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr2", instr2, 16'h0000);
        check("rst_instr_is32", instr_is32, 1'b0);
        check("rst_instr_pc", instr_pc, 16'h0000);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0:       prog[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
                1:       prog[i] = 16'h940C | (16'($urandom) & 16'h01F3);
                default: prog[i] = 16'($urandom);
            endcase
        end

        // fill with consumer stalled: reads at 0..3, then p_rd stays low
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);

        // straight-line program streamed with the consumer always ready
        prog[0] = 16'h50A1; prog[1] = 16'h0000; prog[2] = 16'hE800;
        prog[3] = 16'hE011; prog[4] = 16'h0F01; prog[5] = 16'h0000;
        prog[6] = 16'h0000; prog[7] = 16'h0000; prog[8] = 16'h0000;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // LDS at address 0
        prog[0] = 16'h9100; prog[1] = 16'h0100;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // jump with a real word in flight, then jump from a full queue with p_valid high
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 16'h0020);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        inj_valid = 1'b1;
        step(1'b0, 1'b1, 16'h0040);
        #1 inj_valid = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // reset mid-cycle with the queue half full, stray p_valid after release
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        #2 RST = 1'b0;
        #1;
        check("midrst_p_rd", p_rd, 1'b0);
        check("midrst_instr_valid", instr_valid, 1'b0);
        model_reset();
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        inj_valid = 1'b1;
        step(1'b1, 1'b0, '0);
        #1 inj_valid = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // PC_W = 8 instance: jump to 0xFF wraps to 0x00
        @(negedge CLK);
        jump_en8   = 1'b1;
        jump_addr8 = 8'hFF;
        #1 check("w8_jump_p_rd", p_rd8, 1'b0);
        @(negedge CLK);
        jump_en8 = 1'b0;
        #1;
        check("w8_p_rd0", p_rd8, 1'b1);
        check("w8_p_addr0", p_addr8, 8'hFF);
        @(negedge CLK);
        #1;
        check("w8_p_rd1", p_rd8, 1'b1);
        check("w8_p_addr1", p_addr8, 8'h00);
        @(negedge CLK);
        #1;
        check("w8_valid0", instr_valid8, 1'b1);
        check("w8_pc0", instr_pc8, 8'hFF);
        check("w8_instr0", instr8, 16'h5AFF);
        @(negedge CLK);
        #1;
        check("w8_valid1", instr_valid8, 1'b1);
        check("w8_pc1", instr_pc8, 8'h00);
        check("w8_instr1", instr8, 16'h5A00);
        check("w8_is32", instr_is32_8, 1'b0);
        check("w8_instr2", instr2_8, 16'h0000);

        // random traffic with random redirects
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 32) == 0, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
